// File: rtl/sprite_layer_merger.sv
// Composites prioritised sprite layers over the background and packs the pixels into a
// ping-pong bank pair that a VGA-side reader drains. Also reports screen-edge collisions and sprite overlap.
module sprite_layer_merger #(
  parameter int NUM_SPRITES     = 4,
  parameter int COLOR_W         = 8,
  parameter int PIXELS_PER_WORD = 16,
  parameter int POS_W           = 10,
  parameter int SPRITE_SIZE     = 16,
  parameter int BG_SIZE_X       = 640,
  parameter int BG_SIZE_Y       = 480,
  parameter logic [3*COLOR_W-1:0] TRANS_RGB = 24'h171717
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   frame_start,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  input  logic [3*COLOR_W-1:0]                   bg_rgb,
  input  logic [NUM_SPRITES*3*COLOR_W-1:0]       sp_rgb,
  input  logic [NUM_SPRITES-1:0]                 sp_enable,
  input  logic [NUM_SPRITES*POS_W-1:0]           sp_pos_x,
  input  logic [NUM_SPRITES*POS_W-1:0]           sp_pos_y,
  output logic [PIXELS_PER_WORD*3*COLOR_W-1:0]   rd_word,
  output logic                                   rd_valid,
  input  logic                                   rd_ack,
  output logic                                   rd_sel,
  output logic [4*NUM_SPRITES-1:0]               collision,
  output logic                                   overlap
);

  localparam int PW     = 3*COLOR_W;
  localparam int WORD_W = PIXELS_PER_WORD*PW;
  localparam int CNT_W  = $clog2(PIXELS_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS_PER_WORD-1);
  localparam logic [POS_W:0]   SZ       = (POS_W+1)'(SPRITE_SIZE);
  localparam logic [POS_W:0]   LIM_X    = (POS_W+1)'(BG_SIZE_X);
  localparam logic [POS_W:0]   LIM_Y    = (POS_W+1)'(BG_SIZE_Y);

  // Handshakes: a pixel moves on a rising edge where pix_valid & pix_ready;
  // a bank is consumed on a rising edge where rd_valid & rd_ack.
  typedef enum logic {FILL = 1'b0, STALL = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [WORD_W-1:0]        bank [2];
  logic [1:0]               bank_full;
  logic [CNT_W-1:0]         cnt;
  logic                     fill_sel;
  logic                     fill_toggle;
  logic [NUM_SPRITES-1:0]   opaque;
  logic [PW-1:0]            comp_rgb;
  logic                     multi_opaque;
  logic [4*NUM_SPRITES-1:0] coll_d;
  logic                     accept, last, ack, ack_other;

  assign accept    = pix_valid & pix_ready;
  assign last      = (cnt == LAST_IDX);
  assign ack       = rd_ack & rd_valid;
  assign ack_other = ack & (rd_sel != fill_sel);
  assign rd_valid  = bank_full[rd_sel];
  assign rd_word   = bank[rd_sel];

  // Walk from lowest priority upward so sprite 0 is written last and wins.
  always_comb begin
    comp_rgb     = bg_rgb;
    multi_opaque = 1'b0;
    opaque       = '0;
    for (int i = NUM_SPRITES-1; i >= 0; i--) begin
      opaque[i] = sp_enable[i] && (sp_rgb[i*PW +: PW] != TRANS_RGB);
      if (opaque[i]) comp_rgb = sp_rgb[i*PW +: PW];
    end
    for (int i = 0; i < NUM_SPRITES; i++) begin
      for (int j = i+1; j < NUM_SPRITES; j++) begin
        if (opaque[i] && opaque[j]) multi_opaque = 1'b1;
      end
    end
  end

  always_comb begin
    coll_d = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (sp_enable[i]) begin
        coll_d[4*i+0] = ({1'b0, sp_pos_x[i*POS_W +: POS_W]} + SZ) >= LIM_X;
        coll_d[4*i+1] = (sp_pos_x[i*POS_W +: POS_W] == '0);
        coll_d[4*i+2] = ({1'b0, sp_pos_y[i*POS_W +: POS_W]} + SZ) >= LIM_Y;
        coll_d[4*i+3] = (sp_pos_y[i*POS_W +: POS_W] == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FILL;
    else if (frame_start) state_q <= FILL;
    else state_q <= state_d;
  end

  // An ack of the other bank on the same edge frees it in time, so no stall is needed.
  always_comb begin
    state_d     = state_q;
    fill_toggle = 1'b0;
    case (state_q)
      FILL: begin
        if (accept && last) begin
          if (!bank_full[~fill_sel] || ack_other) fill_toggle = 1'b1;
          else state_d = STALL;
        end
      end
      STALL: begin
        if (!bank_full[~fill_sel] || ack_other) begin
          fill_toggle = 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    pix_ready = (state_q == FILL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank[0]   <= '0;
      bank[1]   <= '0;
      bank_full <= '0;
      cnt       <= '0;
      fill_sel  <= 1'b0;
      rd_sel    <= 1'b0;
      overlap   <= 1'b0;
    end else if (frame_start) begin
      bank_full <= '0;
      cnt       <= '0;
      fill_sel  <= 1'b0;
      rd_sel    <= 1'b0;
      overlap   <= 1'b0;
    end else begin
      if (ack) begin
        bank_full[rd_sel] <= 1'b0;
        rd_sel            <= ~rd_sel;
      end
      if (accept) begin
        bank[fill_sel][cnt*PW +: PW] <= comp_rgb;
        cnt <= last ? '0 : cnt + CNT_W'(1);
        if (last) bank_full[fill_sel] <= 1'b1;
        if (multi_opaque) overlap <= 1'b1;
      end
      if (fill_toggle) fill_sel <= ~fill_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) collision <= '0;
    else collision <= coll_d;
  end

endmodule

// File: tb/tb_sprite_layer_merger.sv
// Randomised bench for sprite_layer_merger: a word-queue reference model predicts
// backpressure, bank rotation, packed words, overlap and collision flags.
module tb_sprite_layer_merger;
  localparam int NS = 4, CW = 8, P = 16, POSW = 10, SS = 16, BGX = 640, BGY = 480;
  localparam int RGBW = 3*CW, WORD_W = P*RGBW;
  localparam logic [RGBW-1:0] TRANS = 24'h171717;

  logic                 clk = 1'b0, reset = 1'b1, frame_start = 1'b0, pix_valid = 1'b0, rd_ack = 1'b0;
  logic                 pix_ready, rd_valid, rd_sel, overlap;
  logic [RGBW-1:0]      bg_rgb = '0;
  logic [NS*RGBW-1:0]   sp_rgb = '0;
  logic [NS-1:0]        sp_enable = '0;
  logic [NS*POSW-1:0]   sp_pos_x = '0, sp_pos_y = '0;
  logic [WORD_W-1:0]    rd_word;
  logic [4*NS-1:0]      collision;

  sprite_layer_merger #(
    .NUM_SPRITES(NS), .COLOR_W(CW), .PIXELS_PER_WORD(P), .POS_W(POSW),
    .SPRITE_SIZE(SS), .BG_SIZE_X(BGX), .BG_SIZE_Y(BGY), .TRANS_RGB(TRANS)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .bg_rgb(bg_rgb), .sp_rgb(sp_rgb), .sp_enable(sp_enable),
    .sp_pos_x(sp_pos_x), .sp_pos_y(sp_pos_y), .rd_word(rd_word), .rd_valid(rd_valid),
    .rd_ack(rd_ack), .rd_sel(rd_sel), .collision(collision), .overlap(overlap)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [RGBW-1:0]   part_q[$];
  bit                exp_sel, exp_ovl;
  logic [4*NS-1:0]   exp_coll;

  task automatic check(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [RGBW-1:0] composite(input logic [RGBW-1:0] bg, input logic [NS*RGBW-1:0] sp,
                                                input logic [NS-1:0] en);
    for (int i = 0; i < NS; i++)
      if (en[i] && sp[i*RGBW +: RGBW] != TRANS) return sp[i*RGBW +: RGBW];
    return bg;
  endfunction

  function automatic int n_opaque(input logic [NS*RGBW-1:0] sp, input logic [NS-1:0] en);
    int n = 0;
    for (int i = 0; i < NS; i++) if (en[i] && sp[i*RGBW +: RGBW] != TRANS) n++;
    return n;
  endfunction

  function automatic logic [3:0] edge_flags(input int x, input int y, input bit en);
    if (!en) return 4'b0000;
    return {y == 0, y + SS >= BGY, x == 0, x + SS >= BGX};
  endfunction

  function automatic logic [RGBW-1:0] rand_rgb();
    case ($urandom_range(0, 3))
      0, 1:    return TRANS;
      2:       return RGBW'($urandom);
      default: return ($urandom_range(0, 1) != 0) ? 24'hFF0000 : 24'h00FF00;
    endcase
  endfunction

  function automatic int rand_pos(input int lim);
    case ($urandom_range(0, 4))
      0: return 0;
      1: return lim - SS;
      2: return lim - SS - 1;
      3: return 1023;
      default: return $urandom_range(0, 1023);
    endcase
  endfunction

  task automatic model_clear();
    exp_q.delete();
    part_q.delete();
    exp_sel = 1'b0;
    exp_ovl = 1'b0;
  endtask

  // Advances the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit acc, ack;
    logic [WORD_W-1:0] w;
    acc = pix_valid && (exp_q.size() < 2);
    ack = rd_ack && (exp_q.size() > 0);
    for (int i = 0; i < NS; i++)
      exp_coll[4*i +: 4] = edge_flags(int'(sp_pos_x[i*POSW +: POSW]), int'(sp_pos_y[i*POSW +: POSW]), sp_enable[i]);
    if (frame_start) begin
      model_clear();
    end else begin
      if (ack) begin
        void'(exp_q.pop_front());
        exp_sel = ~exp_sel;
      end
      if (acc) begin
        part_q.push_back(composite(bg_rgb, sp_rgb, sp_enable));
        if (n_opaque(sp_rgb, sp_enable) >= 2) exp_ovl = 1'b1;
        if (part_q.size() == P) begin
          for (int k = 0; k < P; k++) w[k*RGBW +: RGBW] = part_q[k];
          exp_q.push_back(w);
          part_q.delete();
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("pix_ready", WORD_W'(pix_ready), WORD_W'(exp_q.size() < 2));
    check("rd_valid",  WORD_W'(rd_valid),  WORD_W'(exp_q.size() > 0));
    check("rd_sel",    WORD_W'(rd_sel),    WORD_W'(exp_sel));
    check("overlap",   WORD_W'(overlap),   WORD_W'(exp_ovl));
    check("collision", WORD_W'(collision), WORD_W'(exp_coll));
    if (exp_q.size() > 0) check("rd_word", rd_word, exp_q[0]);
  endtask

  task automatic step(input bit v, input bit a, input bit fs);
    pix_valid = v; rd_ack = a; frame_start = fs;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic randomize_pixel();
    bg_rgb = RGBW'($urandom);
    for (int i = 0; i < NS; i++) begin
      sp_rgb[i*RGBW +: RGBW]   = rand_rgb();
      sp_pos_x[i*POSW +: POSW] = POSW'(rand_pos(BGX));
      sp_pos_y[i*POSW +: POSW] = POSW'(rand_pos(BGY));
    end
    sp_enable = NS'($urandom);
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #2;
    model_clear();
    exp_coll = '0;
    check_outputs();
    check("rd_word_rst", rd_word, '0);
    reset = 1'b0;
  endtask

  logic [WORD_W-1:0] bg_word;

  initial begin
    model_clear();
    exp_coll = '0;
    repeat (2) @(negedge clk);
    async_reset_check();

    // Transparent sprites, constant background word.
    bg_rgb = 24'h112233;
    for (int i = 0; i < NS; i++) sp_rgb[i*RGBW +: RGBW] = TRANS;
    sp_enable = '1;
    for (int k = 0; k < P; k++) begin
      bg_word[k*RGBW +: RGBW] = 24'h112233;
      step(1'b1, 1'b0, 1'b0);
    end
    check("bg_word", rd_word, bg_word);

    // Right/top edge sprite, then disabled.
    sp_enable = 4'b0001; sp_pos_x = '0; sp_pos_y = '0;
    sp_pos_x[POSW-1:0] = POSW'(624);
    step(1'b0, 1'b0, 1'b0);
    check("coll_edge", WORD_W'(collision[3:0]), WORD_W'(4'b1001));
    sp_enable = '0;
    step(1'b0, 1'b0, 1'b0);
    check("coll_off", WORD_W'(collision[3:0]), WORD_W'(4'b0000));
    step(1'b0, 1'b0, 1'b1);

    // Random phases from no drain to full-rate drain.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 400; c++) begin
        randomize_pixel();
        if (ph == 2 && c == 157) async_reset_check();
        step($urandom_range(0, 99) < 80,
             $urandom_range(0, 99) < ph * 33,
             $urandom_range(0, 199) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
